norm_pipe: RTL and testbench

//   Two-stage pipelined normalizer: the inverse of the barrel shift.
//   - Finds the shift amount that brings the leading significant bit to the MSB.
//   - Left-shifts the operand by that amount.
//   - Returns both the normalized value and the shift count.

---
 rtl/norm_pipe_pkg.sv | 17 +
 rtl/norm_pipe_lzc.sv | 47 ++++
 rtl/norm_pipe_shf.sv | 26 ++
 rtl/norm_pipe.sv | 104 ++++++++++
 tb/tb_norm_pipe.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/norm_pipe_pkg.sv
// Shared definitions for the normalizer pipeline.
// Default width, count width and the handshake-advance helper.
package norm_pipe_pkg;

  localparam int W_DEF = 32;
  localparam int TAGW_DEF = 4;
  localparam int LOGW = $clog2(W_DEF);

  // A register slot may load when it is empty or its content leaves.
  function automatic logic adv(
    input logic v,
    input logic rdy
  );
    return !v || rdy;
  endfunction

endpackage

// File: rtl/norm_pipe_lzc.sv
// Combinational leading-zero counter.
// Built as a log2(W)-level tree of pairwise count/all-zero merges.
module lzc
  import norm_pipe_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0]         data,
  output logic [$clog2(W)-1:0] cnt,
  output logic                 allz
);

  localparam int LW = $clog2(W);

  for (genvar l = 0; l <= LW; l++) begin : g_lvl
    localparam int N = W >> l;
    logic [N-1:0]  z;
    logic [LW-1:0] c [N];

    if (l == 0) begin : g_leaf
      assign z = ~data;
      for (genvar i = 0; i < N; i++) begin : g_c
        assign c[i] = '0;
      end
    end else begin : g_node
      for (genvar j = 0; j < N; j++) begin : g_m
        logic          hi_z;
        logic          lo_z;
        logic [LW-1:0] hi_c;
        logic [LW-1:0] lo_c;
        assign hi_z = g_lvl[l-1].z[2*j+1];
        assign lo_z = g_lvl[l-1].z[2*j];
        assign hi_c = g_lvl[l-1].c[2*j+1];
        assign lo_c = g_lvl[l-1].c[2*j];
        assign z[j] = hi_z & lo_z;
        // All-zero upper half contributes its full width.
        assign c[j] = hi_z
          ? LW'((1 << (l - 1)) + int'(lo_c))
          : hi_c;
      end
    end
  end

  assign cnt  = g_lvl[LW].c[0];
  assign allz = g_lvl[LW].z[0];

endmodule

// File: rtl/norm_pipe_shf.sv
// Barrel shifter: logical left, or logical/arithmetic right.
// RIGHT selects direction; sgn selects arithmetic right shift.
module shf
  import norm_pipe_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter bit RIGHT = 1'b0
) (
  input  logic [W-1:0]         data,
  input  logic [$clog2(W)-1:0] amt,
  input  logic                 sgn,
  output logic [W-1:0]         res
);

  logic signed [W-1:0] ar;

  assign ar = $signed(data) >>> amt;

  always_comb begin
    res = data << amt;
    if (RIGHT) begin
      res = sgn ? ar : (data >> amt);
    end
  end

endmodule

// File: rtl/norm_pipe.sv
// Two-stage normalizer: S1 counts leading zeros/sign bits,
// S2 left-shifts by that count. Valid/ready on both sides.
module norm_pipe
  import norm_pipe_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  input  logic                 in_sgn,
  input  logic [TAGW-1:0]      in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(W)-1:0] out_cnt,
  output logic                 out_zero,
  output logic [TAGW-1:0]      out_tag
);

  localparam int LW = $clog2(W);

  logic            s1_v;
  logic [W-1:0]    s1_data;
  logic [LW-1:0]   s1_cnt;
  logic            s1_zero;
  logic [TAGW-1:0] s1_tag;

  logic            s1_adv;
  logic            s2_adv;

  logic [W-1:0]    lz_in;
  logic [LW-1:0]   lz_cnt;
  logic            lz_allz;
  logic            in_zero;
  logic [LW-1:0]   in_cnt;
  logic [W-1:0]    sh_res;

  assign s2_adv   = adv(out_valid, out_ready);
  assign s1_adv   = adv(s1_v, s2_adv);
  assign in_ready = s1_adv;

  // Sign mode: bits matching the MSB become zeros; the
  // appended 1 keeps one redundant sign bit and bounds cnt.
  assign lz_in = in_sgn
    ? {in_data[W-2:0] ^ {(W-1){in_data[W-1]}}, 1'b1}
    : in_data;

  lzc #(.W(W)) u_lzc (
    .data (lz_in),
    .cnt  (lz_cnt),
    .allz (lz_allz)
  );

  assign in_zero = in_sgn
    ? (&in_data) | ~(|in_data)
    : lz_allz;
  assign in_cnt = in_zero ? '0 : lz_cnt;

  shf #(.W(W), .RIGHT(1'b0)) u_shf (
    .data (s1_data),
    .amt  (s1_cnt),
    .sgn  (1'b0),
    .res  (sh_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s1_data   <= '0;
      s1_cnt    <= '0;
      s1_zero   <= 1'b0;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (s1_adv) begin
        s1_v <= in_valid;
      end
      if (in_valid && s1_adv) begin
        s1_data <= in_data;
        s1_cnt  <= in_cnt;
        s1_zero <= in_zero;
        s1_tag  <= in_tag;
      end
      if (s2_adv) begin
        out_valid <= s1_v;
      end
      if (s1_v && s2_adv) begin
        out_data <= sh_res;
        out_cnt  <= s1_cnt;
        out_zero <= s1_zero;
        out_tag  <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_norm_pipe.sv
// Directed self-checking bench for norm_pipe (W=32, TAGW=4).
// Vector table plus streaming, stall and reset sequences.
module tb_norm_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sgn;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_cnt;
  logic        out_zero;
  logic [3:0]  out_tag;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic [31:0] ed;
    logic [4:0]  ec;
    logic        ez;
  } vec_t;

  vec_t v [13];

  always #5 clk = ~clk;

  norm_pipe #(.W(32), .TAGW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sgn    (in_sgn),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(
    input logic        vld,
    input logic [31:0] d,
    input logic        s,
    input logic [3:0]  t
  );
    in_valid = vld;
    in_data  = d;
    in_sgn   = s;
    in_tag   = t;
  endtask

  initial begin
    v[0]  = '{32'h0000_1000, 1'b0, 32'h8000_0000, 5'd19, 1'b0};
    v[1]  = '{32'hFFFF_F800, 1'b1, 32'h8000_0000, 5'd20, 1'b0};
    v[2]  = '{32'h0000_0000, 1'b0, 32'h0000_0000, 5'd0,  1'b1};
    v[3]  = '{32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0};
    v[4]  = '{32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0,  1'b0};
    v[5]  = '{32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 5'd0,  1'b1};
    v[6]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 5'd0,  1'b1};
    v[7]  = '{32'h0000_0001, 1'b1, 32'h4000_0000, 5'd30, 1'b0};
    v[8]  = '{32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 5'd0,  1'b0};
    v[9]  = '{32'h8000_0000, 1'b1, 32'h8000_0000, 5'd0,  1'b0};
    v[10] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 5'd0,  1'b0};
    v[11] = '{32'h00F0_0000, 1'b0, 32'hF000_0000, 5'd8,  1'b0};
    v[12] = '{32'hFFFF_FFFE, 1'b1, 32'h8000_0000, 5'd30, 1'b0};

    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_cnt", 32'(out_cnt), 32'd0);
    chk("rst out_zero", 32'(out_zero), 32'd0);
    chk("rst out_tag", 32'(out_tag), 32'd0);

    // Table vectors, one at a time, exact 2-cycle latency.
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, v[i].d, v[i].s, 4'(i));
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 4'h0);
      chk($sformatf("v%0d early valid", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d data", i), out_data, v[i].ed);
      chk($sformatf("v%0d cnt", i), 32'(out_cnt), 32'(v[i].ec));
      chk($sformatf("v%0d zero", i), 32'(out_zero), 32'(v[i].ez));
      chk($sformatf("v%0d tag", i), 32'(out_tag), 32'(i % 16));
    end
    @(negedge clk);

    // Back-to-back stream of 8 operands.
    for (int c = 0; c < 11; c++) begin
      if (c >= 2 && c < 10) begin
        chk($sformatf("str%0d valid", c), 32'(out_valid), 32'd1);
        chk($sformatf("str%0d tag", c), 32'(out_tag), 32'(c - 2));
        chk($sformatf("str%0d cnt", c), 32'(out_cnt), 32'(28 - (c - 2)));
        chk($sformatf("str%0d data", c), out_data, 32'h8000_0000);
      end else begin
        chk($sformatf("str%0d idle", c), 32'(out_valid), 32'd0);
      end
      if (c < 8) begin
        chk($sformatf("str%0d in_ready", c), 32'(in_ready), 32'd1);
        drive(1'b1, 32'd1 << (c + 3), 1'b0, 4'(c));
      end else begin
        drive(1'b0, 32'h0, 1'b0, 4'h0);
      end
      @(negedge clk);
    end

    // Backpressure: out_ready low, three operands queued.
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0100, 1'b0, 4'd8);
    chk("stl0 in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("stl1 in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h0000_0003, 1'b0, 4'd9);
    @(negedge clk);
    drive(1'b1, 32'hFFFF_0000, 1'b1, 4'd10);
    for (int c = 2; c < 5; c++) begin
      #1;
      chk($sformatf("stl%0d in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("stl%0d valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("stl%0d tag", c), 32'(out_tag), 32'd8);
      chk($sformatf("stl%0d data", c), out_data, 32'h8000_0000);
      chk($sformatf("stl%0d cnt", c), 32'(out_cnt), 32'd23);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("rel in_ready", 32'(in_ready), 32'd1);
    chk("rel tag8", 32'(out_tag), 32'd8);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    chk("rel valid9", 32'(out_valid), 32'd1);
    chk("rel tag9", 32'(out_tag), 32'd9);
    chk("rel data9", out_data, 32'hC000_0000);
    chk("rel cnt9", 32'(out_cnt), 32'd30);
    @(negedge clk);
    chk("rel valid10", 32'(out_valid), 32'd1);
    chk("rel tag10", 32'(out_tag), 32'd10);
    chk("rel data10", out_data, 32'h8000_0000);
    chk("rel cnt10", 32'(out_cnt), 32'd15);
    @(negedge clk);
    chk("rel drained", 32'(out_valid), 32'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0010, 1'b0, 4'd3);
    @(negedge clk);
    drive(1'b1, 32'h0000_0020, 1'b0, 4'd4);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    chk("pre-rst full", 32'(out_valid) + 32'(!in_ready), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("mid-rst out_valid", 32'(out_valid), 32'd0);
    chk("mid-rst in_ready", 32'(in_ready), 32'd1);
    chk("mid-rst out_tag", 32'(out_tag), 32'd0);
    chk("mid-rst out_data", out_data, 32'd0);
    drive(1'b1, 32'h0003_0000, 1'b0, 4'd12);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    chk("post-rst early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("post-rst valid", 32'(out_valid), 32'd1);
    chk("post-rst data", out_data, 32'hC000_0000);
    chk("post-rst cnt", 32'(out_cnt), 32'd14);
    chk("post-rst tag", 32'(out_tag), 32'd12);
    @(negedge clk);
    chk("post-rst single", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
